// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: geometry, opcodes and the
// memory responder FSM states.
package coproc_pkg;

  localparam int MAT_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int ROW_W   = MAT_DIM * ELEM_W;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_SMUL   = 3'd3;
  localparam logic [2:0] OP_DET    = 3'd4;
  localparam logic [2:0] OP_TRANSP = 3'd5;
  localparam logic [2:0] OP_OPP    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FETCH,
    ST_RD_SEND,
    ST_WR_ROWS,
    ST_DONE
  } resp_state_e;

endpackage

// File: rtl/matrix_row_ram.sv
// Row-wide matrix store: one write port, one registered read port.
// Contents are deliberately not reset.
module matrix_row_ram #(
  parameter int ROW_W = 40,
  parameter int ROWS  = 80,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [ROW_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder: streams 5-row matrices out of / into the row store,
// one command per matrix, with an out-of-range address flag reported at done.
module matrix_mem_responder
  import coproc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ROW_W-1:0]  rd_data,
  output logic [2:0]        rd_row,
  output logic              rd_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_data,
  output logic              done,
  output logic              err
);

  localparam int ROWS  = DEPTH * MAT_DIM;
  localparam int IDX_W = $clog2(ROWS);

  resp_state_e       state, state_next;
  logic [2:0]        row, row_next;
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  logic              last_row;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  idx;
  logic [ROW_W-1:0]  ram_q;

  // Row counter holds at the last row instead of wrapping.
  function automatic logic [2:0] sat_inc(input logic [2:0] r);
    return (r == 3'(MAT_DIM - 1)) ? r : r + 3'd1;
  endfunction

  assign last_row = (row == 3'(MAT_DIM - 1));
  assign idx      = oor_q ? '0 : IDX_W'(addr_q) * IDX_W'(MAT_DIM) + IDX_W'(row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      row    <= '0;
      addr_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      state <= state_next;
      row   <= row_next;
      if (state == ST_IDLE && cmd_valid) begin
        addr_q <= cmd_addr;
        oor_q  <= (cmd_addr >= ADDR_W'(DEPTH));
      end
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row;
    cmd_ready  = 1'b0;
    rd_valid   = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          row_next   = '0;
          state_next = cmd_write ? ST_WR_ROWS : ST_RD_FETCH;
        end
      end
      ST_RD_FETCH: begin
        ram_re     = 1'b1;
        state_next = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (last_row) begin
            state_next = ST_DONE;
          end else begin
            row_next   = sat_inc(row);
            state_next = ST_RD_FETCH;
          end
        end
      end
      ST_WR_ROWS: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          // Out-of-range writes complete the handshake but never touch the store.
          ram_we = !oor_q;
          if (last_row) state_next = ST_DONE;
          else          row_next   = sat_inc(row);
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        err        = oor_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM output only changes in RD_FETCH, so the beat holds under backpressure.
  assign rd_data = (rd_valid && !oor_q) ? ram_q : '0;
  assign rd_row  = rd_valid ? row : '0;
  assign rd_last = rd_valid && last_row;

  matrix_row_ram #(
    .ROW_W (ROW_W),
    .ROWS  (ROWS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (idx),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder: command table plus hand-written
// reset, backpressure and busy-collision sequences.
module tb_matrix_mem_responder;
  import coproc_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [7:0]       cmd_addr = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [ROW_W-1:0] rd_data;
  logic [2:0]       rd_row;
  logic             rd_last;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_data = '0;
  logic             done;
  logic             err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic                            wr;
    logic [7:0]                      addr;
    logic [MAT_DIM-1:0][ROW_W-1:0]   rows;
    logic                            err;
    logic                            pulse;
  } vec_t;

  vec_t vecs [9];

  matrix_mem_responder #(.DEPTH(16), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_row    (rd_row),
    .rd_last   (rd_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic wr, input logic [7:0] addr, input logic [7:0] step,
                               input logic [7:0] fill, input logic e, input logic pulse);
    vec_t v;
    logic [7:0] b;
    v.wr = wr; v.addr = addr; v.err = e; v.pulse = pulse;
    for (int r = 0; r < MAT_DIM; r++) begin
      b = 8'(int'(step) * (r + 1)) + fill;
      v.rows[r] = {MAT_DIM{b}};
    end
    return v;
  endfunction

  task automatic issue_cmd(input logic wr, input logic [7:0] addr);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [MAT_DIM-1:0][ROW_W-1:0] rows);
    int n;
    for (int r = 0; r < MAT_DIM; r++) begin
      wr_valid = 1'b1; wr_data = rows[r];
      n = 0;
      while (!wr_ready && n < 100) begin @(negedge clk); n++; end
      check("wr_ready", 64'(wr_ready), 64'(1));
      @(negedge clk);
    end
    wr_valid = 1'b0; wr_data = '0;
  endtask

  task automatic read_beats(input logic [MAT_DIM-1:0][ROW_W-1:0] rows, input logic pulse);
    int n;
    rd_ready = 1'b1;
    for (int r = 0; r < MAT_DIM; r++) begin
      if (pulse && r == 0) begin
        wr_valid = 1'b1; wr_data = '0;
        check("wr_ready_idle_in_read", 64'(wr_ready), 64'(0));
      end
      n = 0;
      while (!rd_valid && n < 100) begin @(negedge clk); n++; wr_valid = 1'b0; end
      check("rd_gap", 64'(n), 64'(1));
      check("rd_data", 64'(rd_data), 64'(rows[r]));
      check("rd_row", 64'(rd_row), 64'(r));
      check("rd_last", 64'(rd_last), 64'(r == MAT_DIM - 1));
      @(negedge clk);
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_done(input logic e);
    check("done", 64'(done), 64'(1));
    check("err", 64'(err), 64'(e));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
  endtask

  task automatic run_vec(input vec_t v);
    issue_cmd(v.wr, v.addr);
    if (v.wr) write_beats(v.rows);
    else      read_beats(v.rows, v.pulse);
    check_done(v.err);
  endtask

  initial begin
    vec_t v3;
    logic [ROW_W-1:0] saved_data;
    logic [2:0]       saved_row;
    logic             prev_stall, bad;
    int               beats, n;

    vecs[0] = mkv(1'b1, 8'd3,  8'h01, 8'h00, 1'b0, 1'b0);
    vecs[1] = mkv(1'b0, 8'd3,  8'h01, 8'h00, 1'b0, 1'b0);
    vecs[2] = mkv(1'b0, 8'd20, 8'h00, 8'h00, 1'b1, 1'b0);
    vecs[3] = mkv(1'b1, 8'd20, 8'h00, 8'hAA, 1'b1, 1'b0);
    vecs[4] = mkv(1'b0, 8'd3,  8'h01, 8'h00, 1'b0, 1'b0);
    vecs[5] = mkv(1'b1, 8'd0,  8'h00, 8'hFF, 1'b0, 1'b0);
    vecs[6] = mkv(1'b0, 8'd0,  8'h00, 8'hFF, 1'b0, 1'b1);
    vecs[7] = mkv(1'b1, 8'd15, 8'h10, 8'h00, 1'b0, 1'b0);
    vecs[8] = mkv(1'b0, 8'd16, 8'h00, 8'h00, 1'b1, 1'b0);
    v3 = vecs[1];

    // Reset values while rst is held
    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    // Addr 15 written with 0x10*(r+1) rows must read back intact
    run_vec(mkv(1'b0, 8'd15, 8'h10, 8'h00, 1'b0, 1'b0));

    // Backpressure: rd_ready toggles every cycle
    issue_cmd(1'b0, 8'd3);
    beats = 0; prev_stall = 1'b0; n = 0;
    saved_data = '0; saved_row = '0;
    while (beats < MAT_DIM && n < 200) begin
      rd_ready = ~rd_ready;
      if (prev_stall) begin
        check("bp_valid_held", 64'(rd_valid), 64'(1));
        check("bp_data_stable", 64'(rd_data), 64'(saved_data));
        check("bp_row_stable", 64'(rd_row), 64'(saved_row));
      end
      prev_stall = rd_valid && !rd_ready;
      saved_data = rd_data; saved_row = rd_row;
      if (rd_valid && rd_ready) begin
        check("bp_data", 64'(rd_data), 64'(v3.rows[beats]));
        check("bp_row", 64'(rd_row), 64'(beats));
        beats++;
      end
      @(negedge clk);
      n++;
    end
    rd_ready = 1'b0;
    check("bp_beats", 64'(beats), 64'(MAT_DIM));
    check_done(1'b0);

    // Busy collision: command held valid throughout a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'd3;
    rd_ready = 1'b1;
    @(negedge clk);
    bad = 1'b0; n = 0;
    while (!done && n < 100) begin
      if (cmd_ready) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("busy_no_ready", 64'(bad), 64'(0));
    check("busy_done", 64'(done), 64'(1));
    check("busy_ready_at_done", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    check("busy_ready_after_done", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    read_beats(v3.rows, 1'b0);
    check_done(1'b0);

    // Asynchronous reset while row 2 is on the bus
    issue_cmd(1'b0, 8'd3);
    rd_ready = 1'b1; n = 0;
    while (!(rd_valid && rd_row == 3'd2) && n < 100) begin @(negedge clk); n++; end
    check("mid_row2_seen", 64'(rd_row), 64'(2));
    rd_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_done", 64'(done), 64'(0));
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
